// File: rtl/cordic_accum_pipe.sv
// -----------------------------------------------------------------------------
// cordic_accum_pipe
//   Fully pipelined rotation-mode CORDIC feeding a bank of saturating
//   accumulators. One operation per enabled cycle, no back-pressure.
//   Pipeline: stage-0 input register (angle clamp), ITER rotation stages,
//   a cos/sin select register, then the accumulate/output register.
//   Latency is ITER+2 enabled edges from the sampling edge to done.
//
// Ports
//   clk     : sole clock, rising edge
//   rst     : asynchronous active-high reset (flushes pipe, clears accs)
//   clk_en  : global enable, low freezes every register
//   start   : issue strobe
//   n       : opcode 0 CLEAR, 1 GO_COS, 2 READ, 3 GO_SIN
//   x_one   : angle in radians, signed Q(W-FRAC).FRAC
//   x_two   : channel select, low log2(NUM_ACC) bits used
//   result  : accumulator value returned by the completing operation
//   done    : one-cycle completion pulse
//   ovf     : sticky saturation flag of the completing operation's channel
// -----------------------------------------------------------------------------
module cordic_accum_pipe #(
  parameter int W       = 32,
  parameter int FRAC    = 16,
  parameter int ITER    = 16,
  parameter int NUM_ACC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         start,
  input  logic [1:0]   n,
  input  logic [W-1:0] x_one,
  input  logic [W-1:0] x_two,
  output logic [W-1:0] result,
  output logic         done,
  output logic         ovf
);

  // Two guard bits keep the rotation free of overflow (|x|,|y| reach ~1.65).
  localparam int DW = W + 2;
  localparam int CW = $clog2(NUM_ACC);

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_COS   = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_SIN   = 2'd3;

  // atan(2^-i) scaled by 2^32; beyond i=12 atan(2^-i) equals 2^-i to
  // well under one 2^-32 LSB.
  function automatic logic [63:0] atan_q32(input int i);
    logic [63:0] v;
    case (i)
      0:       v = 64'd3373259426;
      1:       v = 64'd1991351318;
      2:       v = 64'd1052175346;
      3:       v = 64'd534100635;
      4:       v = 64'd268086748;
      5:       v = 64'd134174063;
      6:       v = 64'd67103403;
      7:       v = 64'd33553749;
      8:       v = 64'd16777131;
      9:       v = 64'd8388597;
      10:      v = 64'd4194303;
      11:      v = 64'd2097152;
      default: v = (i < 32) ? (64'd1 << (32 - i)) : 64'd0;
    endcase
    return v;
  endfunction

  // Round a 2^32-scaled constant down to FRAC fractional bits.
  function automatic logic [63:0] round_q32(input logic [63:0] v);
    return (v + (64'd1 << (31 - FRAC))) >> (32 - FRAC);
  endfunction

  // K * 2^FRAC with K = prod 1/sqrt(1+2^-2i). The product of (1+2^-2i) is
  // built in Q2.60 (each factor is an add-and-shift), its integer square
  // root lands in Q.30, and a rounded divide gives the scaled reciprocal.
  function automatic logic [63:0] k_scaled();
    logic [63:0] p;
    logic [63:0] rem;
    logic [63:0] res;
    logic [63:0] bitv;
    p = 64'd1 << 60;
    for (int i = 0; i < ITER; i++) begin
      p = p + (p >> (2 * i));
    end
    rem  = p;
    res  = 64'd0;
    bitv = 64'd1 << 62;
    for (int b = 0; b < 32; b++) begin
      if (rem >= res + bitv) begin
        rem = rem - (res + bitv);
        res = (res >> 1) + bitv;
      end else begin
        res = res >> 1;
      end
      bitv = bitv >> 2;
    end
    return ((64'd1 << (FRAC + 30)) + (res >> 1)) / res;
  endfunction

  localparam logic [63:0]          K_SCALED = k_scaled();
  localparam logic [63:0]          P_SCALED = round_q32(64'd6746518852);
  localparam logic signed [DW-1:0] K_INIT   = K_SCALED[DW-1:0];
  localparam logic signed [DW-1:0] P_POS    = P_SCALED[DW-1:0];
  localparam logic signed [DW-1:0] P_NEG    = -P_POS;

  // Rotation pipeline; index 0 is the stage-0 input register, index i+1 is
  // the output of rotation stage i.
  logic                 v_q  [0:ITER];
  logic                 v_d  [0:ITER];
  logic [1:0]           op_q [0:ITER];
  logic [1:0]           op_d [0:ITER];
  logic [CW-1:0]        ch_q [0:ITER];
  logic [CW-1:0]        ch_d [0:ITER];
  logic signed [DW-1:0] x_q  [0:ITER];
  logic signed [DW-1:0] x_d  [0:ITER];
  logic signed [DW-1:0] y_q  [0:ITER];
  logic signed [DW-1:0] y_d  [0:ITER];
  logic signed [DW-1:0] z_q  [0:ITER];
  logic signed [DW-1:0] z_d  [0:ITER];

  logic signed [DW-1:0] ang_ext;
  assign ang_ext = {{2{x_one[W-1]}}, x_one};

  assign v_d[0]  = start;
  assign op_d[0] = n;
  assign ch_d[0] = x_two[CW-1:0];
  assign x_d[0]  = K_INIT;
  assign y_d[0]  = '0;
  assign z_d[0]  = (ang_ext > P_POS) ? P_POS :
                   (ang_ext < P_NEG) ? P_NEG : ang_ext;

  generate
    for (genvar gi = 0; gi < ITER; gi++) begin : g_rot
      localparam logic [63:0]          ATAN_S = round_q32(atan_q32(gi));
      localparam logic signed [DW-1:0] ATAN   = ATAN_S[DW-1:0];
      logic signed [DW-1:0] xs;
      logic signed [DW-1:0] ys;
      assign xs = x_q[gi] >>> gi;
      assign ys = y_q[gi] >>> gi;
      // z < 0 selects d = -1; both updates use the pre-update x and y.
      assign x_d[gi+1]  = z_q[gi][DW-1] ? x_q[gi] + ys : x_q[gi] - ys;
      assign y_d[gi+1]  = z_q[gi][DW-1] ? y_q[gi] - xs : y_q[gi] + xs;
      assign z_d[gi+1]  = z_q[gi][DW-1] ? z_q[gi] + ATAN : z_q[gi] - ATAN;
      assign v_d[gi+1]  = v_q[gi];
      assign op_d[gi+1] = op_q[gi];
      assign ch_d[gi+1] = ch_q[gi];
    end
  endgenerate

  // Select register: picks cos or sin, truncated to W bits.
  logic                sel_v_q;
  logic [1:0]          sel_op_q;
  logic [CW-1:0]       sel_ch_q;
  logic [W-1:0]        sel_val_q;
  logic [W-1:0]        sel_val_d;
  assign sel_val_d = (op_q[ITER] == OP_SIN) ? y_q[ITER][W-1:0] : x_q[ITER][W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ITER; i++) begin
        v_q[i]  <= 1'b0;
        op_q[i] <= '0;
        ch_q[i] <= '0;
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        z_q[i]  <= '0;
      end
      sel_v_q   <= 1'b0;
      sel_op_q  <= '0;
      sel_ch_q  <= '0;
      sel_val_q <= '0;
    end else if (clk_en) begin
      for (int i = 0; i <= ITER; i++) begin
        v_q[i]  <= v_d[i];
        op_q[i] <= op_d[i];
        ch_q[i] <= ch_d[i];
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        z_q[i]  <= z_d[i];
      end
      sel_v_q   <= v_q[ITER];
      sel_op_q  <= op_q[ITER];
      sel_ch_q  <= ch_q[ITER];
      sel_val_q <= sel_val_d;
    end
  end

  // Accumulate stage: the only place accumulators are read or written, so
  // operations to one channel observe each other strictly in issue order.
  logic [W-1:0]       acc_q [0:NUM_ACC-1];
  logic [W-1:0]       acc_d [0:NUM_ACC-1];
  logic [NUM_ACC-1:0] ovf_reg_q;
  logic [NUM_ACC-1:0] ovf_reg_d;
  logic               done_q;
  logic               done_d;
  logic [W-1:0]       result_q;
  logic [W-1:0]       result_d;
  logic               ovf_q;
  logic               ovf_d;

  logic [W-1:0] acc_sel;
  logic [W:0]   sum;
  logic         clamp;
  logic [W-1:0] sat_val;

  assign acc_sel = acc_q[sel_ch_q];
  assign sum     = {acc_sel[W-1], acc_sel} + {sel_val_q[W-1], sel_val_q};
  assign clamp   = sum[W] != sum[W-1];
  assign sat_val = !clamp ? sum[W-1:0] :
                   sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};

  always_comb begin
    acc_d     = acc_q;
    ovf_reg_d = ovf_reg_q;
    done_d    = sel_v_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    if (sel_v_q) begin
      case (sel_op_q)
        OP_COS, OP_SIN: begin
          acc_d[sel_ch_q] = sat_val;
          if (clamp) ovf_reg_d[sel_ch_q] = 1'b1;
          result_d = sat_val;
          ovf_d    = clamp | ovf_reg_q[sel_ch_q];
        end
        OP_READ: begin
          result_d = acc_sel;
          ovf_d    = ovf_reg_q[sel_ch_q];
        end
        default: begin
          // CLEAR returns the pre-clear value and flag.
          result_d             = acc_sel;
          ovf_d                = ovf_reg_q[sel_ch_q];
          acc_d[sel_ch_q]      = '0;
          ovf_reg_d[sel_ch_q]  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_q[i] <= '0;
      end
      ovf_reg_q <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else if (clk_en) begin
      acc_q     <= acc_d;
      ovf_reg_q <= ovf_reg_d;
      done_q    <= done_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign ovf    = ovf_q;

  // Final z and guard bits of x/y are not needed downstream.
  logic unused_bits;
  assign unused_bits = ^{z_q[ITER], x_q[ITER][DW-1:W], y_q[ITER][DW-1:W], x_two[W-1:CW]};

endmodule

// File: tb/tb_cordic_accum_pipe.sv
// -----------------------------------------------------------------------------
// tb_cordic_accum_pipe
//   Directed bench for cordic_accum_pipe: a default-parameter instance and a
//   W=20 instance (saturation). Completions are captured per enabled edge with
//   their edge index, so latency is measured in enabled edges only.
// -----------------------------------------------------------------------------
module tb_cordic_accum_pipe;

  localparam int LAT = 18;
  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_COS   = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_SIN   = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic        start2;
  logic [1:0]  n;
  logic [31:0] x_one;
  logic [31:0] x_two;
  logic [31:0] result;
  logic        done;
  logic        ovf;
  logic [19:0] result2;
  logic        done2;
  logic        ovf2;

  always #5 clk = ~clk;

  cordic_accum_pipe #(.W(32), .FRAC(16), .ITER(16), .NUM_ACC(4)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start), .n(n),
    .x_one(x_one), .x_two(x_two), .result(result), .done(done), .ovf(ovf)
  );

  cordic_accum_pipe #(.W(20), .FRAC(16), .ITER(16), .NUM_ACC(4)) dut2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .start(start2), .n(n),
    .x_one(x_one[19:0]), .x_two(x_two[19:0]), .result(result2), .done(done2), .ovf(ovf2)
  );

  typedef struct {
    longint r;
    logic   o;
    int     e;
  } cpl_t;

  cpl_t q1[$];
  cpl_t q2[$];
  int   edge_cnt = 0;
  int   errors   = 0;
  int   checks   = 0;

  always @(posedge clk) begin
    if (clk_en && !rst) edge_cnt++;
  end

  always @(posedge clk) begin
    logic en;
    cpl_t c;
    en = clk_en && !rst;
    #1;
    if (en && !rst) begin
      if (done) begin
        c.r = longint'($signed(result)); c.o = ovf; c.e = edge_cnt;
        q1.push_back(c);
      end
      if (done2) begin
        c.r = longint'($signed(result2)); c.o = ovf2; c.e = edge_cnt;
        q2.push_back(c);
      end
    end
  end

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    longint diff;
    checks++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, got, exp, tol);
    end else begin
      $display("ok   %s: got %0d, want %0d (+/-%0d)", tag, got, exp, tol);
    end
  endtask

  task automatic issue(input bit to2, input logic [1:0] op, input logic [31:0] ang,
                       input logic [31:0] ch, output int ie);
    if (to2) start2 = 1'b1;
    else     start  = 1'b1;
    n     = op;
    x_one = ang;
    x_two = ch;
    ie    = edge_cnt + 1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic get_done(input bit from2, output cpl_t c);
    int t;
    int sz;
    t  = 0;
    sz = from2 ? q2.size() : q1.size();
    while (sz == 0 && t < 100) begin
      @(posedge clk);
      #2;
      t++;
      sz = from2 ? q2.size() : q1.size();
    end
    if (sz == 0) begin
      check("done_wait_cycles", t, 0, 99);
      c.r = 0; c.o = 1'b0; c.e = 0;
    end else if (from2) begin
      c = q2.pop_front();
    end else begin
      c = q1.pop_front();
    end
  endtask

  // Mixed vectors: clamp both signs, channel masking, nonzero angles.
  logic [1:0]  v_op  [6] = '{OP_COS, OP_SIN, OP_COS, OP_READ, OP_COS, OP_SIN};
  logic [31:0] v_ang [6] = '{32'h0005_0000, 32'hFFFB_0000, 32'h0, 32'h0, 32'd68629, 32'd34315};
  logic [31:0] v_ch  [6] = '{32'd2, 32'd3, 32'hFFFF_FFF0, 32'd5, 32'd2, 32'd3};
  longint      v_exp [6] = '{0, -65536, 131072, 65536, 32768, -32768};
  longint      v_tol [6] = '{4, 4, 8, 4, 8, 8};

  // READs issued around a clk_en gap, expected channel contents.
  logic [31:0] r_ch  [4] = '{32'd1, 32'd3, 32'd2, 32'd0};
  longint      r_exp [4] = '{65536, -32768, 32768, 131072};
  longint      r_tol [4] = '{4, 8, 8, 8};

  initial begin
    cpl_t c;
    int   ie;
    int   e0;
    int   ies [16];

    rst = 1'b1; clk_en = 1'b1; start = 1'b0; start2 = 1'b0;
    n = 2'd0; x_one = '0; x_two = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_ovf", ovf, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // cos(0) on ch0, latency in enabled edges
    issue(1'b0, OP_COS, 32'h0, 32'd0, ie);
    get_done(1'b0, c);
    check("cos0_latency", c.e - ie, LAT);
    check("cos0_result", c.r, 65536, 4);
    check("cos0_ovf", c.o, 0);

    // sin(~pi/2) ch1 then READ ch1 next cycle
    issue(1'b0, OP_SIN, 32'h0001_921F, 32'd1, ies[0]);
    issue(1'b0, OP_READ, 32'h0, 32'd1, ies[1]);
    get_done(1'b0, c);
    e0 = c.e;
    check("sin90_result", c.r, 65536, 4);
    check("sin90_latency", c.e - ies[0], LAT);
    get_done(1'b0, c);
    check("read1_result", c.r, 65536, 4);
    check("read1_consecutive", c.e - e0, 1);

    // clamp, masking and general angles, back-to-back
    for (int i = 0; i < 6; i++) issue(1'b0, v_op[i], v_ang[i], v_ch[i], ies[i]);
    for (int i = 0; i < 6; i++) begin
      get_done(1'b0, c);
      check($sformatf("vec%0d_result", i), c.r, v_exp[i], v_tol[i]);
      check($sformatf("vec%0d_ovf", i), c.o, 0);
      check($sformatf("vec%0d_latency", i), c.e - ies[i], LAT);
    end

    // clk_en gap while a done pulse is showing and three ops are in flight
    for (int i = 0; i < 4; i++) issue(1'b0, OP_READ, 32'h0, r_ch[i], ies[i]);
    get_done(1'b0, c);
    check("gap0_result", c.r, r_exp[0], r_tol[0]);
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      check("frozen_done", done, 1);
      check("frozen_result", longint'($signed(result)), r_exp[0], r_tol[0]);
    end
    clk_en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      get_done(1'b0, c);
      check($sformatf("gap%0d_result", i), c.r, r_exp[i], r_tol[i]);
      check($sformatf("gap%0d_latency", i), c.e - ies[i], LAT);
    end

    // W=20 saturation: nine cos(0) into ch0, one into ch1, CLEAR, READ
    for (int k = 0; k < 9; k++) issue(1'b1, OP_COS, 32'h0, 32'd0, ies[k]);
    issue(1'b1, OP_COS, 32'h0, 32'd1, ies[9]);
    issue(1'b1, OP_CLEAR, 32'h0, 32'd0, ies[10]);
    issue(1'b1, OP_READ, 32'h0, 32'd0, ies[11]);
    for (int k = 1; k <= 7; k++) begin
      get_done(1'b1, c);
      check($sformatf("sat_acc%0d", k), c.r, 65536 * k, 4 * k);
      check($sformatf("sat_ovf%0d", k), c.o, 0);
    end
    get_done(1'b1, c);
    check("sat_acc8", c.r, 524287, 32);
    get_done(1'b1, c);
    check("sat_acc9", c.r, 524287);
    check("sat_ovf9", c.o, 1);
    get_done(1'b1, c);
    check("sat_ch1_result", c.r, 65536, 4);
    check("sat_ch1_ovf", c.o, 0);
    get_done(1'b1, c);
    check("clear_result", c.r, 524287);
    check("clear_ovf", c.o, 1);
    check("clear_latency", c.e - ies[10], LAT);
    get_done(1'b1, c);
    check("after_clear_result", c.r, 0);
    check("after_clear_ovf", c.o, 0);

    // asynchronous reset with ten ops in flight
    for (int i = 0; i < 10; i++) issue(1'b0, OP_COS, 32'h0, i % 4, ie);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_done", done, 0);
    check("async_rst_result", result, 0);
    check("async_rst_ovf", ovf, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    check("flushed_done_count", q1.size(), 0);
    for (int i = 0; i < 4; i++) issue(1'b0, OP_READ, 32'h0, i, ies[i]);
    for (int i = 0; i < 4; i++) begin
      get_done(1'b0, c);
      check($sformatf("post_rst_read%0d", i), c.r, 0);
      check($sformatf("post_rst_ovf%0d", i), c.o, 0);
      check($sformatf("post_rst_latency%0d", i), c.e - ies[i], LAT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
